ws2812b_rx: RTL and testbench

Single-wire WS2812B stream decoder: the receiving end of the `ws2812b` serial driver. It oversamples the line on the system clock, classifies each high pulse as a 0 or 1 bit by width, assembles 24-bit GRB pixels MSB-first, and detects the >50 µs latch gap as end-of-frame. It sits on a loopback pin beside the LED-matrix top level, so the 8×8 frame actually emitted (64 pixels) can be checked in hardware and in simulation.

---
 rtl/ws2812b_rx.sv | 180 ++++++++++++++++++
 tb/tb_ws2812b_rx.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_rx.sv
// WS2812B single-wire stream decoder: width-classifies high pulses into bits, assembles 24-bit GRB pixels, flags the latch gap.
// Optional protocol checking (pulse width limits, partial pixel at latch) is enabled with `define WS2812B_RX_ERR_EN.
module ws2812b_rx #(
    parameter int BIT_THRESH   = 7,
    parameter int MIN_HIGH     = 2,
    parameter int MAX_HIGH     = 14,
    parameter int RESET_CYCLES = 600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ws2812b_in,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [5:0]  pixel_idx,
    output logic        frame_done,
    output logic [6:0]  frame_pixels,
    output logic        err
);

`ifdef WS2812B_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int              LW        = $clog2(RESET_CYCLES + 1);
    localparam logic [LW-1:0]   LCNT_LAST = LW'(RESET_CYCLES - 1);
    localparam logic [LW-1:0]   LCNT_FULL = LW'(RESET_CYCLES);
    localparam logic [7:0]      THRESH8   = 8'(BIT_THRESH);
    localparam logic [7:0]      MIN8      = 8'(MIN_HIGH);
    localparam logic [7:0]      MAX8      = 8'(MAX_HIGH);

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    state_t         state_q, state_n;
    logic           sync1_q, s_q, s_d_q;
    logic           rise, fall, bit_val;
    logic [7:0]     hcnt_q, hcnt_n;
    logic [LW-1:0]  lcnt_q, lcnt_n;
    logic [4:0]     bit_cnt_q, bit_cnt_n;
    logic [6:0]     pix_cnt_q, pix_cnt_n;
    logic [22:0]    shreg_q, shreg_n;
    logic [23:0]    pixel_data_n;
    logic [5:0]     pixel_idx_n;
    logic [6:0]     frame_pixels_n;
    logic           pixel_valid_n, frame_done_n, err_n;

    assign rise    = s_q & ~s_d_q;
    assign fall    = ~s_q & s_d_q;
    assign bit_val = (hcnt_q >= THRESH8);

    always_comb begin
        state_n        = state_q;
        hcnt_n         = hcnt_q;
        lcnt_n         = lcnt_q;
        bit_cnt_n      = bit_cnt_q;
        pix_cnt_n      = pix_cnt_q;
        shreg_n        = shreg_q;
        pixel_data_n   = pixel_data;
        pixel_idx_n    = pixel_idx;
        frame_pixels_n = frame_pixels;
        pixel_valid_n  = 1'b0;
        frame_done_n   = 1'b0;
        err_n          = 1'b0;

        case (state_q)
            ARM: begin
                bit_cnt_n = '0;
                pix_cnt_n = '0;
                if (s_q) begin
                    lcnt_n = '0;
                end else if (lcnt_q == LCNT_LAST) begin
                    lcnt_n  = LCNT_FULL;
                    state_n = IDLE;
                end else begin
                    lcnt_n = lcnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (rise) begin
                    hcnt_n  = 8'd1;
                    state_n = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    if (ERR_EN && (hcnt_q < MIN8)) begin
                        err_n   = 1'b1;
                        lcnt_n  = '0;
                        state_n = ARM;
                    end else begin
                        shreg_n = {shreg_q[21:0], bit_val};
                        lcnt_n  = LW'(1);
                        state_n = LOW;
                        if (bit_cnt_q == 5'd23) begin
                            pixel_data_n  = {shreg_q, bit_val};
                            pixel_valid_n = 1'b1;
                            pixel_idx_n   = pix_cnt_q[5:0];
                            pix_cnt_n     = (pix_cnt_q == 7'h7F) ? pix_cnt_q : pix_cnt_q + 7'd1;
                            bit_cnt_n     = '0;
                        end else begin
                            bit_cnt_n = bit_cnt_q + 5'd1;
                        end
                    end
                end else if (ERR_EN && (hcnt_q >= MAX8)) begin
                    // The pulse is still high and about to exceed the legal width.
                    err_n   = 1'b1;
                    lcnt_n  = '0;
                    state_n = ARM;
                end else if (hcnt_q != 8'hFF) begin
                    hcnt_n = hcnt_q + 8'd1;
                end
            end
            LOW: begin
                if (rise) begin
                    hcnt_n  = 8'd1;
                    state_n = HIGH;
                end else if (lcnt_q == LCNT_LAST) begin
                    // Latch gap: close the frame and drop any partial pixel.
                    lcnt_n  = LCNT_FULL;
                    state_n = IDLE;
                    if (pix_cnt_q != 7'd0) begin
                        frame_done_n   = 1'b1;
                        frame_pixels_n = pix_cnt_q;
                    end
                    if (ERR_EN && (bit_cnt_q != 5'd0)) begin
                        err_n = 1'b1;
                    end
                    bit_cnt_n = '0;
                    pix_cnt_n = '0;
                end else begin
                    lcnt_n = lcnt_q + 1'b1;
                end
            end
            default: state_n = ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            s_q          <= 1'b0;
            s_d_q        <= 1'b0;
            state_q      <= ARM;
            hcnt_q       <= '0;
            lcnt_q       <= '0;
            bit_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            shreg_q      <= '0;
            pixel_data   <= '0;
            pixel_valid  <= 1'b0;
            pixel_idx    <= '0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            err          <= 1'b0;
        end else begin
            sync1_q      <= ws2812b_in;
            s_q          <= sync1_q;
            s_d_q        <= s_q;
            state_q      <= state_n;
            hcnt_q       <= hcnt_n;
            lcnt_q       <= lcnt_n;
            bit_cnt_q    <= bit_cnt_n;
            pix_cnt_q    <= pix_cnt_n;
            shreg_q      <= shreg_n;
            pixel_data   <= pixel_data_n;
            pixel_valid  <= pixel_valid_n;
            pixel_idx    <= pixel_idx_n;
            frame_done   <= frame_done_n;
            frame_pixels <= frame_pixels_n;
            err          <= err_n;
        end
    end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Bench for ws2812b_rx: pin-level run-length model checked every cycle, pixel scoreboard, directed scenarios.
`timescale 1ns/1ps
module tb_ws2812b_rx;

    localparam int BIT_THRESH   = 7;
    localparam int MIN_HIGH     = 2;
    localparam int MAX_HIGH     = 14;
    localparam int RESET_CYCLES = 600;
`ifdef WS2812B_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ws2812b_in = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [5:0]  pixel_idx;
    logic        frame_done;
    logic [6:0]  frame_pixels;
    logic        err;

    ws2812b_rx #(
        .BIT_THRESH  (BIT_THRESH),
        .MIN_HIGH    (MIN_HIGH),
        .MAX_HIGH    (MAX_HIGH),
        .RESET_CYCLES(RESET_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ws2812b_in  (ws2812b_in),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_idx   (pixel_idx),
        .frame_done  (frame_done),
        .frame_pixels(frame_pixels),
        .err         (err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Works on the synchronized line as run lengths of high/low samples.
    logic        model_live = 1'b0;
    logic        m_p1, m_p2, m_ps;
    logic        m_armed, m_infr;
    int          m_low, m_high, m_bits, m_pix;
    logic [23:0] m_word;
    logic [23:0] exp_data;
    logic        exp_valid, exp_done, exp_err;
    logic [5:0]  exp_idx;
    logic [6:0]  exp_fp;
    logic [29:0] exp_q[$];

    task automatic model_disarm();
        exp_err = 1'b1;
        m_armed = 1'b0;
        m_infr  = 1'b0;
        m_low   = 0;
        m_bits  = 0;
        m_pix   = 0;
    endtask

    task automatic model_step();
        logic s;
        if (!rst_n) begin
            m_p1 = 0; m_p2 = 0; m_ps = 0;
            m_armed = 0; m_infr = 0;
            m_low = 0; m_high = 0; m_bits = 0; m_pix = 0; m_word = '0;
            exp_data = '0; exp_valid = 0; exp_idx = '0;
            exp_done = 0; exp_fp = '0; exp_err = 0;
            exp_q.delete();
            model_live = 1'b1;
            return;
        end
        s = m_p2;
        m_p2 = m_p1;
        m_p1 = ws2812b_in;
        exp_valid = 0; exp_done = 0; exp_err = 0;
        if (!m_armed) begin
            if (s) m_low = 0;
            else begin
                m_low++;
                if (m_low == RESET_CYCLES) m_armed = 1;
            end
        end else if (s) begin
            m_high = m_ps ? m_high + 1 : 1;
            m_infr = 1;
            if (ERR_EN && m_high > MAX_HIGH) model_disarm();
        end else if (m_ps) begin
            if (ERR_EN && m_high < MIN_HIGH) model_disarm();
            else begin
                m_word = {m_word[22:0], (m_high >= BIT_THRESH)};
                m_bits++;
                m_low = 1;
                if (m_bits == 24) begin
                    exp_valid = 1;
                    exp_data  = m_word;
                    exp_idx   = 6'(m_pix % 64);
                    exp_q.push_back({exp_idx, exp_data});
                    m_pix++;
                    m_bits = 0;
                end
            end
        end else if (m_infr) begin
            m_low++;
            if (m_low == RESET_CYCLES) begin
                if (m_pix > 0) begin
                    exp_done = 1;
                    exp_fp   = 7'((m_pix > 127) ? 127 : m_pix);
                end
                if (ERR_EN && m_bits != 0) exp_err = 1;
                m_bits = 0;
                m_pix  = 0;
                m_infr = 0;
            end
        end
        m_ps = s;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- compare process / scoreboard ----------------
    int          pv_cnt = 0, fd_cnt = 0, err_cnt = 0;
    logic [23:0] last_pv_data = '0;
    logic [5:0]  last_pv_idx = '0;
    int          last_pv_cyc = 0;
    logic [6:0]  last_fp = '0;

    initial forever begin
        @(negedge clk);
        if (model_live) begin
            check("pixel_data",   32'(pixel_data),   32'(exp_data));
            check("pixel_valid",  32'(pixel_valid),  32'(exp_valid));
            check("pixel_idx",    32'(pixel_idx),    32'(exp_idx));
            check("frame_done",   32'(frame_done),   32'(exp_done));
            check("frame_pixels", 32'(frame_pixels), 32'(exp_fp));
            check("err",          32'(err),          32'(exp_err));
            if (pixel_valid === 1'b1) begin
                pv_cnt++;
                last_pv_data = pixel_data;
                last_pv_idx  = pixel_idx;
                last_pv_cyc  = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pix_sb act=%0h exp=none", {pixel_idx, pixel_data});
                end else begin
                    check("pix_sb", 32'({pixel_idx, pixel_data}), 32'(exp_q.pop_front()));
                end
            end
            if (frame_done === 1'b1) begin
                fd_cnt++;
                last_fp = frame_pixels;
            end
            if (err === 1'b1) err_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    int last_fall_cyc = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        ws2812b_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_bit(input int hi, input int period);
        ws2812b_in = 1'b1;
        repeat (hi) tick();
        ws2812b_in = 1'b0;
        last_fall_cyc = cyc;
        repeat (period - hi) tick();
    endtask

    task automatic send_pixel(input logic [23:0] d, input int hi1, input int hi0,
                              input int period, input int last_low);
        for (int i = 23; i >= 1; i--) send_bit(d[i] ? hi1 : hi0, period);
        ws2812b_in = 1'b1;
        repeat (d[0] ? hi1 : hi0) tick();
        ws2812b_in = 1'b0;
        last_fall_cyc = cyc;
        repeat (last_low) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  32'(pixel_data),   32'h0);
        check({tag, "_valid"}, 32'(pixel_valid),  32'h0);
        check({tag, "_idx"},   32'(pixel_idx),    32'h0);
        check({tag, "_done"},  32'(frame_done),   32'h0);
        check({tag, "_fp"},    32'(frame_pixels), 32'h0);
        check({tag, "_err"},   32'(err),          32'h0);
    endtask

    // ---------------- directed sequence ----------------
    int pv0, fd0, e0;

    initial begin
        rst_n = 1'b0;
        ws2812b_in = 1'b0;
        repeat (4) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Single pixel after the arming gap.
        idle(RESET_CYCLES + 10);
        pv0 = pv_cnt;
        send_pixel(24'hFF9000, 10, 5, 15, 10);
        check("p0_count", 32'(pv_cnt - pv0), 32'd1);
        check("p0_data", 32'(last_pv_data), 32'hFF9000);
        check("p0_idx", 32'(last_pv_idx), 32'd0);
        check("p0_latency", 32'(last_pv_cyc - last_fall_cyc), 32'd3);
        fd0 = fd_cnt;
        idle(RESET_CYCLES + 5);
        check("p0_frame_done", 32'(fd_cnt - fd0), 32'd1);
        check("p0_frame_pixels", 32'(last_fp), 32'd1);

        // Full 8x8 frame.
        pv0 = pv_cnt; fd0 = fd_cnt; e0 = err_cnt;
        for (int k = 0; k < 64; k++) send_pixel(24'(k) << 18, 10, 5, 15, 10);
        idle(RESET_CYCLES + 5);
        check("frame_strobes", 32'(pv_cnt - pv0), 32'd64);
        check("frame_last_idx", 32'(last_pv_idx), 32'd63);
        check("frame_last_data", 32'(last_pv_data), 32'hFC0000);
        check("frame_done_cnt", 32'(fd_cnt - fd0), 32'd1);
        check("frame_pixels64", 32'(last_fp), 32'd64);
        check("frame_no_err", 32'(err_cnt - e0), 32'd0);

        // Threshold boundary: 7 -> 1, 6 -> 0.
        pv0 = pv_cnt;
        send_pixel(24'hAAAAAA, 7, 6, 15, 10);
        check("thr_count", 32'(pv_cnt - pv0), 32'd1);
        check("thr_data", 32'(last_pv_data), 32'hAAAAAA);
        check("thr_idx", 32'(last_pv_idx), 32'd0);
`ifdef WS2812B_RX_ERR_EN
        e0 = err_cnt; pv0 = pv_cnt;
        send_bit(14, 20);
        send_bit(15, 20);
        check("max_err", 32'(err_cnt - e0), 32'd1);
        for (int i = 0; i < 22; i++) send_bit(10, 15);
        idle(10);
        check("max_no_pixel", 32'(pv_cnt - pv0), 32'd0);
        idle(RESET_CYCLES + 5);
        send_pixel(24'h5A5A5A, 10, 5, 15, 10);
        check("max_recover_data", 32'(last_pv_data), 32'h5A5A5A);
        check("max_recover_idx", 32'(last_pv_idx), 32'd0);
`else
        send_pixel(24'hF0F0F0, 15, 1, 20, 10);
        check("wide_data", 32'(last_pv_data), 32'hF0F0F0);
        check("wide_idx", 32'(last_pv_idx), 32'd1);
`endif
        idle(RESET_CYCLES + 5);

        // Partial pixel before the latch gap.
        fd0 = fd_cnt; e0 = err_cnt;
        for (int i = 0; i < 12; i++) send_bit(10, 15);
        idle(RESET_CYCLES + 5);
        check("partial_no_done", 32'(fd_cnt - fd0), 32'd0);
        check("partial_err", 32'(err_cnt - e0), ERR_EN ? 32'd1 : 32'd0);
        send_pixel(24'h123456, 10, 5, 15, 10);
        check("partial_next_data", 32'(last_pv_data), 32'h123456);
        check("partial_next_idx", 32'(last_pv_idx), 32'd0);
        idle(RESET_CYCLES + 5);

        // Reset mid-pixel, then data without a gap is ignored.
        for (int i = 0; i < 10; i++) send_bit(10, 15);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        pv0 = pv_cnt;
        send_pixel(24'hC3C3C3, 10, 5, 15, 10);
        check("nogap_ignored", 32'(pv_cnt - pv0), 32'd0);
        idle(RESET_CYCLES + 5);
        send_pixel(24'h00FF00, 10, 5, 15, 10);
        check("rearm_count", 32'(pv_cnt - pv0), 32'd1);
        check("rearm_data", 32'(last_pv_data), 32'h00FF00);
        check("rearm_idx", 32'(last_pv_idx), 32'd0);

        // 599-cycle low run does not close the frame; 600 does.
        fd0 = fd_cnt;
        send_pixel(24'h111111, 10, 5, 15, RESET_CYCLES - 1);
        check("gap599_idx", 32'(last_pv_idx), 32'd1);
        send_pixel(24'h222222, 10, 5, 15, RESET_CYCLES);
        idle(5);
        check("gap600_idx", 32'(last_pv_idx), 32'd2);
        check("gap600_done", 32'(fd_cnt - fd0), 32'd1);
        check("gap600_fp", 32'(last_fp), 32'd3);

        idle(5);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
